// File: rtl/rf_wr_channel_merge.sv
// Merges NUM_CH write-back channels into one register-file write port.
// Each channel has a small FIFO. A round-robin arbiter picks the channel to write, and writes to x0 are dropped.
module rf_wr_channel_merge #(
  parameter  int RV64   = 0,
  parameter  int NUM_CH = 2,
  parameter  int DEPTH  = 2,
  parameter  int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int XLEN   = 32 * (1 + RV64)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_CH-1:0]      in_vld,
  input  logic [NUM_CH*5-1:0]    in_rd,
  input  logic [NUM_CH*XLEN-1:0] in_dat,
  output logic [NUM_CH-1:0]      in_rdy,
  output logic                   out_vld,
  output logic [4:0]             out_rd,
  output logic [XLEN-1:0]        out_dat,
  output logic [CH_W-1:0]        out_ch,
  input  logic                   out_rdy,
  output logic [31:0]            pend_mask
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [4:0]      rd_mem_q  [NUM_CH][DEPTH];
  logic [XLEN-1:0] dat_mem_q [NUM_CH][DEPTH];
  logic [PTR_W-1:0] wptr_q [NUM_CH], wptr_d [NUM_CH];
  logic [PTR_W-1:0] rptr_q [NUM_CH], rptr_d [NUM_CH];
  logic [CNT_W-1:0] cnt_q  [NUM_CH], cnt_d  [NUM_CH];
  logic [CH_W-1:0]  rr_q, rr_d;
  logic [CH_W-1:0]  lock_ch_q;
  logic             lock_q;

  logic [NUM_CH-1:0] req, push, pop;
  logic [CH_W-1:0]   gnt;
  logic              pop_fire;

  // An rd=0 beat completes its handshake but is never stored.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      in_rdy[i] = (cnt_q[i] != CNT_W'(DEPTH));
      push[i]   = in_vld[i] & in_rdy[i] & (in_rd[5*i +: 5] != 5'd0);
      req[i]    = (cnt_q[i] != '0);
    end
  end

  // While a beat is stalled, the grant stays on the locked channel so the output does not change.
  always_comb begin
    int  idx;
    logic found;
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    if (lock_q) begin
      gnt = lock_ch_q;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        idx = (int'(rr_q) + k) % NUM_CH;
        if (!found && req[idx]) begin
          gnt   = CH_W'(idx);
          found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    out_vld  = |req;
    out_rd   = '0;
    out_dat  = '0;
    out_ch   = '0;
    if (out_vld) begin
      out_rd  = rd_mem_q[gnt][rptr_q[gnt]];
      out_dat = dat_mem_q[gnt][rptr_q[gnt]];
      out_ch  = gnt;
    end
    pop_fire = out_vld & out_rdy;
    for (int i = 0; i < NUM_CH; i++) begin
      pop[i] = pop_fire && (gnt == CH_W'(i));
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (pop_fire) rr_d = CH_W'((int'(gnt) + 1) % NUM_CH);
    for (int i = 0; i < NUM_CH; i++) begin
      wptr_d[i] = push[i] ? wptr_q[i] + 1'b1 : wptr_q[i];
      rptr_d[i] = pop[i]  ? rptr_q[i] + 1'b1 : rptr_q[i];
      cnt_d[i]  = cnt_q[i];
      if (push[i] && !pop[i]) cnt_d[i] = cnt_q[i] + 1'b1;
      if (!push[i] && pop[i]) cnt_d[i] = cnt_q[i] - 1'b1;
    end
  end

  // An entry counts as pending when its offset from the read pointer is below the occupancy.
  always_comb begin
    logic [PTR_W-1:0] off;
    off       = '0;
    pend_mask = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      for (int e = 0; e < DEPTH; e++) begin
        off = PTR_W'(e) - rptr_q[i];
        if ({1'b0, off} < cnt_q[i]) pend_mask[rd_mem_q[i][e]] = 1'b1;
      end
    end
    pend_mask[0] = 1'b0;
  end

  // NOTE: the storage arrays have no reset. Occupancy is tracked by cnt_q, so stale contents are never observed.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (push[i]) begin
        rd_mem_q[i][wptr_q[i]]  <= in_rd[5*i +: 5];
        dat_mem_q[i][wptr_q[i]] <= in_dat[XLEN*i +: XLEN];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      rr_q      <= '0;
      lock_q    <= 1'b0;
      lock_ch_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        wptr_q[i] <= wptr_d[i];
        rptr_q[i] <= rptr_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
      rr_q      <= rr_d;
      lock_q    <= out_vld & ~out_rdy;
      lock_ch_q <= gnt;
    end
  end

endmodule

// File: tb/tb_rf_wr_channel_merge.sv
// Directed bench for rf_wr_channel_merge. It covers a 32-bit two-channel instance and a 64-bit instance.
module tb_rf_wr_channel_merge;

  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  logic [1:0]  in_vld;
  logic [9:0]  in_rd;
  logic [63:0] in_dat;
  logic [1:0]  in_rdy;
  logic        out_vld;
  logic [4:0]  out_rd;
  logic [31:0] out_dat;
  logic [0:0]  out_ch;
  logic        out_rdy;
  logic [31:0] pend_mask;

  logic [1:0]   in_vld64;
  logic [9:0]   in_rd64;
  logic [127:0] in_dat64;
  logic [1:0]   in_rdy64;
  logic         out_vld64;
  logic [4:0]   out_rd64;
  logic [63:0]  out_dat64;
  logic [0:0]   out_ch64;
  logic         out_rdy64;
  logic [31:0]  pend_mask64;

  rf_wr_channel_merge #(.RV64(0), .NUM_CH(2), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_vld(in_vld), .in_rd(in_rd), .in_dat(in_dat), .in_rdy(in_rdy),
    .out_vld(out_vld), .out_rd(out_rd), .out_dat(out_dat), .out_ch(out_ch),
    .out_rdy(out_rdy), .pend_mask(pend_mask)
  );

  rf_wr_channel_merge #(.RV64(1), .NUM_CH(2), .DEPTH(2)) dut64 (
    .clk(clk), .rst_n(rst_n),
    .in_vld(in_vld64), .in_rd(in_rd64), .in_dat(in_dat64), .in_rdy(in_rdy64),
    .out_vld(out_vld64), .out_rd(out_rd64), .out_dat(out_dat64), .out_ch(out_ch64),
    .out_rdy(out_rdy64), .pend_mask(pend_mask64)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_vld = '0;
    in_rd  = '0;
    in_dat = '0;
  endtask

  task automatic drive(input int ch, input logic [4:0] rd, input logic [31:0] dat);
    in_vld[ch]        = 1'b1;
    in_rd[5*ch +: 5]  = rd;
    in_dat[32*ch +: 32] = dat;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  int exp_rd [6] = '{1, 9, 2, 10, 3, 11};
  int exp_ch [6] = '{0, 1, 0, 1, 0, 1};
  int src0   [3] = '{1, 2, 3};
  int src1   [3] = '{9, 10, 11};

  initial begin
    int  i0, i1, nout;
    logic a0, a1;

    idle();
    out_rdy   = 1'b1;
    in_vld64  = '0;
    in_rd64   = '0;
    in_dat64  = '0;
    out_rdy64 = 1'b0;
    apply_reset();

    // Reset state
    check("rst_out_vld", out_vld, 0);
    check("rst_out_rd", out_rd, 0);
    check("rst_out_dat", out_dat, 0);
    check("rst_out_ch", out_ch, 0);
    check("rst_in_rdy", in_rdy, 2'b11);
    check("rst_pend", pend_mask, 0);
    check("rst64_out_vld", out_vld64, 0);
    check("rst64_in_rdy", in_rdy64, 2'b11);

    // Single beat, one-cycle latency
    drive(0, 5'd5, 32'h1234);
    step();
    idle();
    check("t1_out_vld", out_vld, 1);
    check("t1_out_rd", out_rd, 5);
    check("t1_out_dat", out_dat, 32'h1234);
    check("t1_out_ch", out_ch, 0);
    check("t1_pend", pend_mask, 32'h0000_0020);
    step();
    check("t1_out_vld_after", out_vld, 0);
    check("t1_pend_after", pend_mask, 0);

    // Round-robin alternation with both channels pushing
    apply_reset();
    i0 = 0; i1 = 0; nout = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (out_vld) begin
        if (nout < 6) begin
          check("rr_rd", out_rd, exp_rd[nout]);
          check("rr_ch", out_ch, exp_ch[nout]);
          check("rr_dat", out_dat, exp_rd[nout] * 32'h101);
        end
        nout++;
      end
      idle();
      if (i0 < 3) drive(0, 5'(src0[i0]), src0[i0] * 32'h101);
      if (i1 < 3) drive(1, 5'(src1[i1]), src1[i1] * 32'h101);
      a0 = in_vld[0] & in_rdy[0];
      a1 = in_vld[1] & in_rdy[1];
      step();
      if (a0) i0++;
      if (a1) i1++;
    end
    idle();
    check("rr_count", nout, 6);

    // Backpressure: fill ch0, grant holds against a higher-priority arrival
    drive(0, 5'd4, 32'h44);
    step();
    idle();
    step();
    out_rdy = 1'b0;
    drive(0, 5'd7, 32'h77);
    step();
    check("bp_out_vld", out_vld, 1);
    check("bp_in_rdy_one", in_rdy[0], 1);
    idle();
    drive(0, 5'd8, 32'h88);
    step();
    idle();
    check("bp_in_rdy_full", in_rdy[0], 0);
    check("bp_rd_stable", out_rd, 7);
    check("bp_dat_stable", out_dat, 32'h77);
    drive(1, 5'd12, 32'hCC);
    step();
    idle();
    check("bp_hold_ch", out_ch, 0);
    check("bp_hold_rd", out_rd, 7);
    check("bp_pend", pend_mask, 32'h0000_1180);
    out_rdy = 1'b1;
    step();
    out_rdy = 1'b0;
    check("bp_in_rdy_back", in_rdy[0], 1);
    check("bp_pend_after", pend_mask, 32'h0000_1100);
    check("bp_next_ch", out_ch, 1);
    check("bp_next_rd", out_rd, 12);
    out_rdy = 1'b1;
    step();
    check("bp_drain_rd", out_rd, 8);
    step();
    check("bp_drained", out_vld, 0);

    // x0 writes are accepted and dropped
    drive(1, 5'd0, 32'hFFFF);
    check("x0_in_rdy", in_rdy[1], 1);
    step();
    idle();
    check("x0_out_vld", out_vld, 0);
    check("x0_pend", pend_mask, 0);
    step();
    check("x0_out_vld_late", out_vld, 0);

    // 64-bit datapath
    in_vld64           = 2'b01;
    in_rd64[4:0]       = 5'd31;
    in_dat64[63:0]     = 64'hDEAD_BEEF_CAFE_F00D;
    step();
    in_vld64 = '0;
    check("w64_out_vld", out_vld64, 1);
    check("w64_out_rd", out_rd64, 31);
    check("w64_out_dat", out_dat64, 64'hDEAD_BEEF_CAFE_F00D);
    check("w64_pend", pend_mask64, 32'h8000_0000);
    step();
    check("w64_pend_held", pend_mask64, 32'h8000_0000);
    out_rdy64 = 1'b1;
    step();
    check("w64_pend_clear", pend_mask64, 0);
    check("w64_out_vld_clear", out_vld64, 0);

    // Mid-stream reset discards buffered entries
    out_rdy = 1'b0;
    drive(0, 5'd1, 32'h1);
    drive(1, 5'd3, 32'h3);
    step();
    idle();
    drive(0, 5'd2, 32'h2);
    drive(1, 5'd4, 32'h4);
    step();
    idle();
    check("mr_full", in_rdy, 2'b00);
    check("mr_pend_full", pend_mask, 32'h0000_001E);
    #2 rst_n = 1'b0;
    #1;
    check("mr_out_vld", out_vld, 0);
    check("mr_pend", pend_mask, 0);
    check("mr_in_rdy", in_rdy, 2'b11);
    step();
    rst_n   = 1'b1;
    out_rdy = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      check("mr_no_stale", out_vld, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
